// File: rtl/mu0_sequencer_if.sv
// rtl/mu0_sequencer_if.sv - MU0 sequencer bus: RUN/memory inputs, phase strobes and IR outputs.
// SINGLE_STEP_EN adds step_mode/step inputs and the paused output.
interface mu0_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4
);
   logic              run;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              fetch;
   logic              exec1;
   logic              exec2;
   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] ir;
   logic              halted;
   logic              instr_done;
   logic              illegal;
`ifdef SINGLE_STEP_EN
   logic              step_mode;
   logic              step;
   logic              paused;

   modport master (
      input  run, mem_rdata, mem_ready, step_mode, step,
      output fetch, exec1, exec2, op, ir, halted, instr_done, illegal, paused
   );
   modport slave (
      output run, mem_rdata, mem_ready, step_mode, step,
      input  fetch, exec1, exec2, op, ir, halted, instr_done, illegal, paused
   );
`else
   modport master (
      input  run, mem_rdata, mem_ready,
      output fetch, exec1, exec2, op, ir, halted, instr_done, illegal
   );
   modport slave (
      output run, mem_rdata, mem_ready,
      input  fetch, exec1, exec2, op, ir, halted, instr_done, illegal
   );
`endif
endinterface

// File: rtl/mu0_sequencer.sv
// rtl/mu0_sequencer.sv - MU0 phase sequencer and instruction register.
// Optional single-step PAUSE state is enabled by defining SINGLE_STEP_EN.
module mu0_sequencer #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   mu0_sequencer_if.master     bus_io
);

   // One-hot so each phase strobe is a single flop bit of the state register.
`ifdef SINGLE_STEP_EN
   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_FETCH = 6'b000010,
      S_EXEC1 = 6'b000100,
      S_EXEC2 = 6'b001000,
      S_HALT  = 6'b010000,
      S_PAUSE = 6'b100000
   } state_e;
`else
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_FETCH = 5'b00010,
      S_EXEC1 = 5'b00100,
      S_EXEC2 = 5'b01000,
      S_HALT  = 5'b10000
   } state_e;
`endif

   localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
   localparam logic [OP_W-1:0] OP_STP = OP_W'(4'h7);
   localparam logic [OP_W-1:0] OP_ILL = OP_W'(4'hB);

   state_e            state_q;
   logic [DATA_W-1:0] ir_q;
   logic              run_q;
   logic [OP_W-1:0]   op;
   logic              start;
   logic              needs_exec2;
   logic              is_stp;
   state_e            retire_d;

   assign op          = ir_q[DATA_W-1 -: OP_W];
   assign start       = bus_io.run & ~run_q;
   assign needs_exec2 = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
   assign is_stp      = (op == OP_STP);

`ifdef SINGLE_STEP_EN
   logic step_q;
   logic step_rise;

   assign step_rise = bus_io.step & ~step_q;
   assign retire_d  = bus_io.step_mode ? S_PAUSE : S_FETCH;
`else
   assign retire_d  = S_FETCH;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         run_q   <= 1'b0;
`ifdef SINGLE_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         run_q <= bus_io.run;
`ifdef SINGLE_STEP_EN
         step_q <= bus_io.step;
`endif
         case (state_q)
            S_IDLE, S_HALT: begin
               if (start) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (bus_io.mem_ready) begin
                  ir_q    <= bus_io.mem_rdata;
                  state_q <= S_EXEC1;
               end
            end
            S_EXEC1: begin
               if (needs_exec2)  state_q <= S_EXEC2;
               else if (is_stp)  state_q <= S_HALT;
               else              state_q <= retire_d;
            end
            S_EXEC2: begin
               if (bus_io.mem_ready) state_q <= retire_d;
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
               if (!bus_io.step_mode || step_rise) state_q <= S_FETCH;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_io.fetch      = (state_q == S_FETCH);
   assign bus_io.exec1      = (state_q == S_EXEC1);
   assign bus_io.exec2      = (state_q == S_EXEC2);
   assign bus_io.halted     = (state_q == S_HALT);
   assign bus_io.op         = op;
   assign bus_io.ir         = ir_q;
   // Retire is in EXEC1 for one-cycle ops (incl. STP), else on the EXEC2 memory handshake.
   assign bus_io.instr_done = ((state_q == S_EXEC1) && !needs_exec2) ||
                              ((state_q == S_EXEC2) && bus_io.mem_ready);
   assign bus_io.illegal    = (state_q == S_EXEC1) && (op >= OP_ILL);
`ifdef SINGLE_STEP_EN
   assign bus_io.paused     = (state_q == S_PAUSE);
`endif

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb/tb_mu0_sequencer.sv - directed self-checking bench for mu0_sequencer.
module tb_mu0_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   mu0_sequencer_if #(.DATA_W(16), .OP_W(4)) bus ();

   mu0_sequencer #(.DATA_W(16), .OP_W(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h0123;
`ifdef SINGLE_STEP_EN
      bus.step_mode = 1'b0;
      bus.step      = 1'b0;
`endif
      #3;
      chk("rst_fetch",  32'(bus.fetch),      32'd0);
      chk("rst_exec1",  32'(bus.exec1),      32'd0);
      chk("rst_exec2",  32'(bus.exec2),      32'd0);
      chk("rst_halted", 32'(bus.halted),     32'd0);
      chk("rst_done",   32'(bus.instr_done), 32'd0);
      chk("rst_ill",    32'(bus.illegal),    32'd0);
      chk("rst_ir",     32'(bus.ir),         32'h0);
      #9 rst_n = 1'b1;

      // LDA 0x123 with zero waits: FETCH, EXEC1, EXEC2, FETCH
      tick();
      chk("lda_c1_fetch", 32'(bus.fetch), 32'd1);
      chk("lda_c1_exec1", 32'(bus.exec1), 32'd0);
      tick();
      chk("lda_c2_exec1", 32'(bus.exec1),      32'd1);
      chk("lda_c2_op",    32'(bus.op),         32'h0);
      chk("lda_c2_ir",    32'(bus.ir),         32'h0123);
      chk("lda_c2_done",  32'(bus.instr_done), 32'd0);
      tick();
      chk("lda_c3_exec2", 32'(bus.exec2),      32'd1);
      chk("lda_c3_done",  32'(bus.instr_done), 32'd1);
      tick();
      chk("lda_c4_fetch", 32'(bus.fetch),      32'd1);
      chk("lda_c4_done",  32'(bus.instr_done), 32'd0);

      // JMP fetched after three wait states
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'h4050;
      tick();
      tick();
      tick();
      chk("jmp_wait_fetch", 32'(bus.fetch), 32'd1);
      chk("jmp_wait_ir",    32'(bus.ir),    32'h0123);
      bus.mem_ready = 1'b1;
      tick();
      chk("jmp_exec1", 32'(bus.exec1),      32'd1);
      chk("jmp_op",    32'(bus.op),         32'h4);
      chk("jmp_done",  32'(bus.instr_done), 32'd1);
      tick();
      chk("jmp_fetch", 32'(bus.fetch), 32'd1);
      chk("jmp_exec2", 32'(bus.exec2), 32'd0);

      // STP halts; held RUN does not restart, a fresh edge does
      bus.mem_rdata = 16'h7000;
      tick();
      chk("stp_exec1", 32'(bus.exec1),      32'd1);
      chk("stp_done",  32'(bus.instr_done), 32'd1);
      tick();
      chk("stp_halted", 32'(bus.halted), 32'd1);
      chk("stp_fetch",  32'(bus.fetch),  32'd0);
      tick();
      tick();
      chk("stp_hold_halted", 32'(bus.halted), 32'd1);
      bus.run = 1'b0;
      tick();
      chk("stp_runlow_halted", 32'(bus.halted), 32'd1);
      bus.run = 1'b1;
      tick();
      chk("restart_fetch",  32'(bus.fetch),  32'd1);
      chk("restart_halted", 32'(bus.halted), 32'd0);

      // Illegal opcode 0xC: one-cycle NOP
      bus.mem_rdata = 16'hC000;
      tick();
      chk("ill_pulse", 32'(bus.illegal),    32'd1);
      chk("ill_done",  32'(bus.instr_done), 32'd1);
      chk("ill_op",    32'(bus.op),         32'hC);
      tick();
      chk("ill_fetch", 32'(bus.fetch),   32'd1);
      chk("ill_exec2", 32'(bus.exec2),   32'd0);
      chk("ill_clear", 32'(bus.illegal), 32'd0);

      // ADD stalled in EXEC2, then asynchronous reset
      bus.mem_rdata = 16'h2ABC;
      tick();
      chk("add_exec1", 32'(bus.exec1), 32'd1);
      bus.mem_ready = 1'b0;
      tick();
      tick();
      chk("add_exec2_hold", 32'(bus.exec2),      32'd1);
      chk("add_exec2_done", 32'(bus.instr_done), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_exec2", 32'(bus.exec2), 32'd0);
      chk("arst_ir",    32'(bus.ir),    32'h0);
      chk("arst_fetch", 32'(bus.fetch), 32'd0);
      bus.run = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      chk("idle_fetch", 32'(bus.fetch), 32'd0);
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      tick();
      chk("idle_start_fetch", 32'(bus.fetch), 32'd1);

`ifdef SINGLE_STEP_EN
      // Single step: pause after EXEC1, held STEP does not release, a STEP edge does
      bus.step_mode = 1'b1;
      bus.mem_rdata = 16'h1005;
      tick();
      chk("ss_exec1", 32'(bus.exec1), 32'd1);
      bus.step = 1'b1;
      tick();
      chk("ss_paused", 32'(bus.paused), 32'd1);
      chk("ss_fetch",  32'(bus.fetch),  32'd0);
      tick();
      chk("ss_hold_paused", 32'(bus.paused), 32'd1);
      bus.step = 1'b0;
      tick();
      chk("ss_low_paused", 32'(bus.paused), 32'd1);
      bus.step = 1'b1;
      tick();
      chk("ss_step_fetch",  32'(bus.fetch),  32'd1);
      chk("ss_step_paused", 32'(bus.paused), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
